fetch_ctrl: RTL and testbench

Sequencing controller for the fetch unit: drives the PC register's Init/Stall/Branch/Target controls from decode-stage requests. Handles program start, halt, multi-cycle memory stalls, external stalls and one-cycle post-branch squash. Sits between decoder/data-memory handshakes and the PC register.

---
 rtl/fetch_ctrl.sv | 90 +++++++++
 tb/tb_fetch_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: drives PC Init/Stall/Branch/Target from decode requests; define FETCH_PERF_CNT_EN for perf counters
module fetch_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             Init,
  input  logic             Start,
  input  logic             HaltInst,
  input  logic             BranchReq,
  input  logic [2:0]       BranchTgt,
  input  logic             MemReq,
  input  logic             ExtStall,
  output logic             PcInit,
  output logic             Stall,
  output logic             Branch,
  output logic [2:0]       Target,
  output logic             Flush,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstCnt,
  output logic [CNT_W-1:0] StallCnt
);
  typedef enum logic [2:0] {IDLE, RUN, MEMWAIT, FLUSH, HALT} state_t;
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);
  state_t     r_state;
  logic [2:0] r_cnt;
  logic       w_run, w_mw, w_fl, w_halt, w_idle, w_run_stall;
  assign w_run       = r_state == RUN;
  assign w_mw        = r_state == MEMWAIT;
  assign w_fl        = r_state == FLUSH;
  assign w_halt      = r_state == HALT;
  assign w_idle      = !(w_run | w_mw | w_fl | w_halt);
  assign w_run_stall = ExtStall | HaltInst | MemReq;
  // outputs are combinational so a request steers the PC on the same edge
  assign PcInit  = w_idle | (w_halt & Start);
  assign Stall   = w_idle | w_halt | (w_run & w_run_stall) | (w_mw & (ExtStall | r_cnt != 3'd0)) | (w_fl & ExtStall);
  assign Branch  = w_run & !w_run_stall & BranchReq;
  assign Target  = Branch ? BranchTgt : 3'd0;
  assign Flush   = w_fl;
  assign Running = w_run | w_mw | w_fl;
  assign Done    = w_halt;
  always_ff @(posedge CLK) begin
    if (Init) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        IDLE:    if (Start) r_state <= RUN;
        RUN: begin
          if (!ExtStall) begin
            if (HaltInst) r_state <= HALT;
            else if (MemReq) begin
              r_state <= MEMWAIT;
              r_cnt   <= LAT_M1;
            end else if (BranchReq) r_state <= FLUSH;
          end
        end
        MEMWAIT: begin
          if (!ExtStall) begin
            if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
            else r_state <= RUN;
          end
        end
        FLUSH:   if (!ExtStall) r_state <= RUN;
        HALT:    if (Start) r_state <= RUN;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] r_inst, r_stall;
  logic             w_start_acc;
  assign w_start_acc = Start & (w_idle | w_halt);
  always_ff @(posedge CLK) begin
    if (Init || w_start_acc) begin
      r_inst  <= '0;
      r_stall <= '0;
    end else if (Running) begin
      if (Stall) r_stall <= r_stall + CNT_W'(~&r_stall);
      else r_inst <= r_inst + CNT_W'(~&r_inst);
    end
  end
  assign InstCnt  = r_inst;
  assign StallCnt = r_stall;
`else
  assign InstCnt  = '0;
  assign StallCnt = '0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed plan plus random stimulus against a behavioural model of the fetch sequencer
module tb_fetch_ctrl;
  localparam int MEM_LAT = 2;
  localparam int CNT_W   = 16;
  localparam int CMAX    = (1 << CNT_W) - 1;
  logic             CLK = 1'b0;
  logic             Init, Start, HaltInst, BranchReq, MemReq, ExtStall;
  logic [2:0]       BranchTgt;
  logic             PcInit, Stall, Branch, Flush, Running, Done;
  logic [2:0]       Target;
  logic [CNT_W-1:0] InstCnt, StallCnt;
  int n_checks = 0;
  int n_fails  = 0;
  bit started, halted, flush_pend, mem_busy;
  int mem_left, m_inst, m_stall;
  fetch_ctrl #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Init(Init), .Start(Start), .HaltInst(HaltInst), .BranchReq(BranchReq),
    .BranchTgt(BranchTgt), .MemReq(MemReq), .ExtStall(ExtStall), .PcInit(PcInit),
    .Stall(Stall), .Branch(Branch), .Target(Target), .Flush(Flush), .Running(Running),
    .Done(Done), .InstCnt(InstCnt), .StallCnt(StallCnt)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input bit init, input bit st, input bit ht, input bit br, input logic [2:0] tgt, input bit mem, input bit ext);
    bit e_pci, e_stall, e_br, e_fl, e_run, e_done;
    int e_tgt;
    @(negedge CLK);
    Init = init; Start = st; HaltInst = ht; BranchReq = br; BranchTgt = tgt; MemReq = mem; ExtStall = ext;
    assert (!(mem && br)) else $error("MemReq and BranchReq driven together");
    #1;
    e_pci = 0; e_stall = 0; e_br = 0; e_fl = 0; e_done = 0;
    e_run = started && !halted;
    if (!started) begin e_pci = 1; e_stall = 1; end
    else if (halted) begin e_stall = 1; e_done = 1; e_pci = st; end
    else if (flush_pend) begin e_fl = 1; e_stall = ext; end
    else if (mem_busy) e_stall = ext || mem_left > 0;
    else begin
      e_stall = ext || ht || mem;
      e_br = !e_stall && br;
    end
    e_tgt = e_br ? int'(tgt) : 0;
    chk("PcInit", PcInit, e_pci);
    chk("Stall", Stall, e_stall);
    chk("Branch", Branch, e_br);
    chk("Target", Target, e_tgt);
    chk("Flush", Flush, e_fl);
    chk("Running", Running, e_run);
    chk("Done", Done, e_done);
`ifdef FETCH_PERF_CNT_EN
    chk("InstCnt", InstCnt, m_inst);
    chk("StallCnt", StallCnt, m_stall);
`else
    chk("InstCnt", InstCnt, 0);
    chk("StallCnt", StallCnt, 0);
`endif
    @(posedge CLK);
    if (init) begin
      started = 0; halted = 0; flush_pend = 0; mem_busy = 0; mem_left = 0; m_inst = 0; m_stall = 0;
    end else begin
      if (st && (!started || halted)) begin m_inst = 0; m_stall = 0; end
      else if (e_run && e_stall) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
      else if (e_run) m_inst = (m_inst == CMAX) ? CMAX : m_inst + 1;
      if (!started) started = st;
      else if (halted) halted = !st;
      else if (flush_pend) flush_pend = ext;
      else if (mem_busy) begin
        if (!ext) begin
          if (mem_left > 0) mem_left--;
          else mem_busy = 0;
        end
      end else if (!ext) begin
        if (ht) halted = 1;
        else if (mem) begin mem_busy = 1; mem_left = MEM_LAT - 1; end
        else if (br) flush_pend = 1;
      end
    end
  endtask
  initial begin
    Init = 1; Start = 0; HaltInst = 0; BranchReq = 0; BranchTgt = 0; MemReq = 0; ExtStall = 0;
    started = 0; halted = 0; flush_pend = 0; mem_busy = 0; mem_left = 0; m_inst = 0; m_stall = 0;
    @(posedge CLK);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3'b110, 0, 0);
    cyc(0, 0, 0, 1, 3'b011, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 3'b010, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3'b001, 0, 1);
    cyc(0, 0, 0, 1, 3'b001, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit b, m;
      b = ($urandom_range(3) == 0);
      m = !b && ($urandom_range(5) == 0);
      cyc($urandom_range(63) == 0, $urandom_range(7) == 0, $urandom_range(15) == 0, b,
          3'($urandom_range(7)), m, $urandom_range(3) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
